square_analyzer: RTL and testbench

Receive-side companion to the square-wave generator. It consumes the generator's signed 16-bit sample stream, qualified by the same sample-rate strobe. It slices the stream to a logic level and measures period and high time in samples. It classifies the duty cycle into the generator's 2-bit code and reports lock/loss status to the control and monitor logic.

---
 rtl/square_analyzer.sv | 189 ++++++++++++++++++
 tb/tb_square_analyzer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/square_analyzer.sv
// Square-wave analyzer: slices a strobed sample stream, measures period/high time, classifies duty, tracks lock.
// Build option SQUARE_ANALYZER_HYST_EN selects the HI_TH/LO_TH hysteresis slicer; otherwise the sign bit decides.
module square_analyzer #(
    parameter int                 CNT_W      = 16,
    parameter int                 MAX_PERIOD = 4096,
    parameter int                 LOCK_COUNT = 3,
    parameter logic signed [15:0] HI_TH      = 16'sd8192,
    parameter logic signed [15:0] LO_TH      = -16'sd8192
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [15:0]      sample_in,
    output logic                    level,
    output logic [CNT_W-1:0]        period,
    output logic [CNT_W-1:0]        high_time,
    output logic [1:0]              dc_code,
    output logic                    meas_valid,
    output logic                    locked,
    output logic                    loss,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int               MC_W   = $clog2(LOCK_COUNT + 1);
    localparam int               EW     = CNT_W + 4;
    localparam logic [CNT_W-1:0] MAX_P  = CNT_W'(MAX_PERIOD);
    localparam logic [MC_W-1:0]  LOCK_N = MC_W'(LOCK_COUNT);

    state_t             state_q, state_d;
    logic               level_q, level_d;
    logic [CNT_W-1:0]   cnt_p_q, cnt_p_d;
    logic [CNT_W-1:0]   cnt_h_q, cnt_h_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic [1:0]         dc_q, dc_d;
    logic               mv_q, mv_d;
    logic               locked_q, locked_d;
    logic               loss_q, loss_d;
    logic [MC_W-1:0]    match_q, match_d;
    logic               first_q, first_d;

    logic               new_level;
    logic               rise;
    logic               same;
    logic [1:0]         dc_new;
    logic [EW-1:0]      p_x, h_x;

`ifdef SQUARE_ANALYZER_HYST_EN
    // Inside the band the slicer keeps its previous decision.
    always_comb begin
        new_level = level_q;
        if (sample_in >= HI_TH)
            new_level = 1'b1;
        else if (sample_in <= LO_TH)
            new_level = 1'b0;
    end
`else
    assign new_level = (sample_in >= 16'sd0);
`endif

    assign rise = clk_en && new_level && !level_q;

    // Thresholds 3/16, 3/8, 5/8 of the period separate the four duty classes.
    always_comb begin
        p_x = EW'(cnt_p_q);
        h_x = EW'(cnt_h_q);
        if ((h_x << 4) < (p_x + (p_x << 1)))
            dc_new = 2'b00;
        else if ((h_x << 3) < (p_x + (p_x << 1)))
            dc_new = 2'b01;
        else if ((h_x << 3) < (p_x + (p_x << 2)))
            dc_new = 2'b10;
        else
            dc_new = 2'b11;
    end

    assign same = !first_q && (cnt_p_q == period_q) && (dc_new == dc_q);

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        cnt_p_d  = cnt_p_q;
        cnt_h_d  = cnt_h_q;
        period_d = period_q;
        high_d   = high_q;
        dc_d     = dc_q;
        mv_d     = 1'b0;
        locked_d = locked_q;
        loss_d   = 1'b0;
        match_d  = match_q;
        first_d  = first_q;
        if (clk_en) begin
            level_d = new_level;
            if (rise) begin
                cnt_p_d = CNT_W'(1);
                cnt_h_d = CNT_W'(1);
                case (state_q)
                    ST_SEARCH: begin
                        state_d = ST_MEASURE;
                        first_d = 1'b1;
                        match_d = '0;
                    end
                    ST_MEASURE, ST_LOCKED: begin
                        period_d = cnt_p_q;
                        high_d   = cnt_h_q;
                        dc_d     = dc_new;
                        mv_d     = 1'b1;
                        first_d  = 1'b0;
                        if (state_q == ST_MEASURE) begin
                            if (same) begin
                                match_d = match_q + 1'b1;
                                if (match_d == LOCK_N) begin
                                    state_d  = ST_LOCKED;
                                    locked_d = 1'b1;
                                end
                            end else begin
                                match_d = '0;
                            end
                        end else if (!same) begin
                            state_d  = ST_MEASURE;
                            locked_d = 1'b0;
                            match_d  = '0;
                        end
                    end
                    default: state_d = ST_SEARCH;
                endcase
            end else if (state_q != ST_SEARCH) begin
                // No rising edge within MAX_PERIOD samples: drop back and wait for a fresh edge.
                if (cnt_p_q == MAX_P) begin
                    loss_d   = 1'b1;
                    locked_d = 1'b0;
                    cnt_p_d  = '0;
                    cnt_h_d  = '0;
                    match_d  = '0;
                    state_d  = ST_SEARCH;
                end else begin
                    cnt_p_d = cnt_p_q + 1'b1;
                    cnt_h_d = cnt_h_q + CNT_W'(new_level);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SEARCH;
            level_q  <= 1'b0;
            cnt_p_q  <= '0;
            cnt_h_q  <= '0;
            period_q <= '0;
            high_q   <= '0;
            dc_q     <= 2'b00;
            mv_q     <= 1'b0;
            locked_q <= 1'b0;
            loss_q   <= 1'b0;
            match_q  <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            cnt_p_q  <= cnt_p_d;
            cnt_h_q  <= cnt_h_d;
            period_q <= period_d;
            high_q   <= high_d;
            dc_q     <= dc_d;
            mv_q     <= mv_d;
            locked_q <= locked_d;
            loss_q   <= loss_d;
            match_q  <= match_d;
            first_q  <= first_d;
        end
    end

    assign level      = level_q;
    assign period     = period_q;
    assign high_time  = high_q;
    assign dc_code    = dc_q;
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign loss       = loss_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_square_analyzer.sv
// Directed bench for square_analyzer: duty classes, strobed input, relock, timeout, slicer noise and reset.
module tb_square_analyzer;
    localparam int CNT_W = 16;
    localparam logic signed [15:0] HI = 16'sh7fff;
    localparam logic signed [15:0] LO = 16'sh8000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b0;
    logic signed [15:0] sample_in = 16'sd0;
    logic level, meas_valid, locked, loss;
    logic [CNT_W-1:0] period, high_time;
    logic [1:0] dc_code, dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_pub = 0;
    int n_loss = 0;
    int gap = 0;

    square_analyzer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .sample_in(sample_in),
        .level(level), .period(period), .high_time(high_time), .dc_code(dc_code),
        .meas_valid(meas_valid), .locked(locked), .loss(loss), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic tick(input logic signed [15:0] s, input logic en);
        @(negedge clk);
        sample_in = s;
        clk_en = en;
        @(posedge clk);
        #1;
        if (meas_valid === 1'b1) n_pub++;
        if (loss === 1'b1) n_loss++;
    endtask

    task automatic send(input logic signed [15:0] s);
        tick(s, 1'b1);
        for (int g = 0; g < gap; g++) tick(~s, 1'b0);
    endtask

    task automatic run_period(input int nh, input int nl);
        for (int i = 0; i < nh; i++) send(HI);
        for (int i = 0; i < nl; i++) send(LO);
    endtask

    task automatic run_noisy_period();
        for (int i = 0; i < 128; i++) send(HI);
        for (int k = 0; k < 128; k++) begin
            if (k == 0) send(LO);
            else if (k == 10 || k == 40) send(16'sd100);
            else send(-16'sd100);
        end
    endtask

    // Reset is held with an active strobe and a high sample to show it overrides them.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clk_en = 1'b1;
        sample_in = HI;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        clk_en = 1'b0;
        n_pub = 0;
        n_loss = 0;
    endtask

    task automatic check_reset_state();
        check("rst_level", level, 0);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_dc", dc_code, 0);
        check("rst_mv", meas_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_loss", loss, 0);
        check("rst_state", dbg_state, 0);
    endtask

    initial begin
        // dc=00: 32 high / 224 low, strobe every cycle
        do_reset();
        check_reset_state();
        gap = 0;
        for (int p = 0; p < 4; p++) run_period(32, 224);
        check("dc00_pubs_before_lock", n_pub, 3);
        check("dc00_unlocked_edge4", locked, 0);
        send(HI);
        check("dc00_mv", meas_valid, 1);
        check("dc00_period", period, 256);
        check("dc00_high", high_time, 32);
        check("dc00_code", dc_code, 0);
        check("dc00_locked_edge5", locked, 1);
        check("dc00_state", dbg_state, 2);
        send(HI);
        check("dc00_mv_one_clk", meas_valid, 0);

        // dc=11: 192 high / 64 low, strobe 1-in-4
        do_reset();
        gap = 3;
        for (int p = 0; p < 5; p++) run_period(192, 64);
        tick(HI, 1'b1);
        check("dc11_mv", meas_valid, 1);
        check("dc11_period", period, 256);
        check("dc11_high", high_time, 192);
        check("dc11_code", dc_code, 3);
        check("dc11_locked", locked, 1);
        tick(LO, 1'b0);
        check("dc11_mv_drop", meas_valid, 0);
        check("dc11_level_hold", level, 1);
        check("dc11_period_hold", period, 256);
        tick(LO, 1'b0);
        check("dc11_level_hold2", level, 1);
        check("dc11_locked_hold", locked, 1);
        gap = 0;

        // Locked at dc=10, then switch to dc=01
        do_reset();
        for (int p = 0; p < 5; p++) run_period(128, 128);
        check("dc10_locked", locked, 1);
        check("dc10_dc", dc_code, 2);
        run_period(64, 192);
        send(HI);
        check("sw_dc", dc_code, 1);
        check("sw_high", high_time, 64);
        check("sw_period", period, 256);
        check("sw_unlocked", locked, 0);
        check("sw_state", dbg_state, 1);
        run_period(63, 192);
        run_period(64, 192);
        run_period(64, 192);
        check("sw_unlocked_edge9", locked, 0);
        send(HI);
        check("sw_relocked_edge10", locked, 1);
        check("sw_pubs", n_pub, 9);

        // Timeout while locked at dc=10
        do_reset();
        for (int p = 0; p < 5; p++) run_period(128, 128);
        send(HI);
        for (int i = 0; i < 127; i++) send(HI);
        for (int i = 0; i < 3968; i++) send(LO);
        check("to_no_loss_yet", n_loss, 0);
        check("to_locked_before", locked, 1);
        send(LO);
        check("to_loss_pulse", loss, 1);
        check("to_unlocked", locked, 0);
        check("to_state_search", dbg_state, 0);
        check("to_period_hold", period, 256);
        check("to_dc_hold", dc_code, 2);
        send(LO);
        check("to_loss_one_clk", loss, 0);
        check("to_loss_count", n_loss, 1);
        n_pub = 0;
        send(HI);
        check("to_edge_no_pub", meas_valid, 0);
        check("to_state_measure", dbg_state, 1);
        check("to_pub_count", n_pub, 0);

        // Noise of +-100 inside the low phase of a dc=10 stream
        do_reset();
        for (int p = 0; p < 6; p++) run_noisy_period();
        send(HI);
`ifdef SQUARE_ANALYZER_HYST_EN
        check("hyst_period", period, 256);
        check("hyst_high", high_time, 128);
        check("hyst_dc", dc_code, 2);
        check("hyst_locked", locked, 1);
        check("hyst_pubs", n_pub, 6);
`else
        check("nohyst_period", period, 88);
        check("nohyst_high", high_time, 1);
        check("nohyst_dc", dc_code, 0);
        check("nohyst_locked", locked, 0);
        check("nohyst_pubs", n_pub, 18);
`endif

        // Reset mid-period while locked, then relock
        do_reset();
        for (int p = 0; p < 5; p++) run_period(128, 128);
        send(HI);
        for (int i = 0; i < 50; i++) send(HI);
        check("mid_locked_before", locked, 1);
        do_reset();
        check_reset_state();
        for (int p = 0; p < 4; p++) run_period(128, 128);
        check("mid_unlocked_edge4", locked, 0);
        send(HI);
        check("mid_relocked_edge5", locked, 1);
        check("mid_period", period, 256);
        check("mid_pubs", n_pub, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
